dcache_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the processor's memory stage and the main-memory model.
- Consumes the processor's ALUOut (address), WriteData, MemWrite and LoadM. Returns ReadData and dhit; the processor stalls while dhit=0.
- Backing memory is reached through a line-wide request/ready handshake.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_if.sv | 14 +
 rtl/dcache_array.sv | 66 ++++++
 rtl/dcache_dm.sv | 167 ++++++++++++++++
 tb/tb_dcache_dm.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    function automatic int calc_offw(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idxw(input int nlines);
        return $clog2(nlines);
    endfunction

    function automatic int calc_tagw(input int offw, input int idxw);
        return 30 - offw - idxw;
    endfunction

    // Field extractors return 32 bits; callers size-cast to the field width.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offw);
        return (addr >> 2) & ((32'd1 << offw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offw, input int idxw);
        return (addr >> (2 + offw)) & ((32'd1 << idxw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tagw);
        return addr >> (32 - tagw);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Line-wide request/ready handshake between the cache and backing memory.
interface dcache_if #(parameter int LW = 128);
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read port, one synchronous write
// port that either merges a word (marking dirty) or fills a whole line.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NLINES     = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [calc_idxw(NLINES)-1:0]                  rd_idx,
    output logic [calc_tagw(calc_offw(LINE_WORDS), calc_idxw(NLINES))-1:0] rd_tag,
    output logic                                          rd_valid,
    output logic                                          rd_dirty,
    output logic [32*LINE_WORDS-1:0]                      rd_line,
    input  logic                                          wr_en,
    input  logic                                          wr_fill,
    input  logic [calc_idxw(NLINES)-1:0]                  wr_idx,
    input  logic [calc_offw(LINE_WORDS)-1:0]              wr_off,
    input  logic [calc_tagw(calc_offw(LINE_WORDS), calc_idxw(NLINES))-1:0] wr_tag,
    input  logic [31:0]                                   wr_word,
    input  logic [32*LINE_WORDS-1:0]                      wr_line
);
    localparam int OFFW = calc_offw(LINE_WORDS);
    localparam int IDXW = calc_idxw(NLINES);
    localparam int TAGW = calc_tagw(OFFW, IDXW);
    localparam int LW   = 32 * LINE_WORDS;

    logic [NLINES-1:0] valid_r;
    logic [NLINES-1:0] dirty_r;
    logic [TAGW-1:0]   tag_r  [NLINES];
    logic [LW-1:0]     data_r [NLINES];

    assign rd_tag   = tag_r[rd_idx];
    assign rd_valid = valid_r[rd_idx];
    assign rd_dirty = dirty_r[rd_idx];
    assign rd_line  = data_r[rd_idx];

    // Line status bits; the only state cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (wr_en) begin
            if (wr_fill) begin
                valid_r[wr_idx] <= 1'b1;
                dirty_r[wr_idx] <= 1'b0;
            end else begin
                dirty_r[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data payload, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                data_r[wr_idx] <= wr_line;
                tag_r[wr_idx]  <= wr_tag;
            end else begin
                data_r[wr_idx][{wr_off, 5'd0} +: 32] <= wr_word;
            end
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache: hit logic, word select
// and the miss-handling FSM in front of a line-wide memory handshake.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int NLINES     = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadM,
    input  logic        MemWrite,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        dhit,
    dcache_if.master    mem
);
    localparam int OFFW = calc_offw(LINE_WORDS);
    localparam int IDXW = calc_idxw(NLINES);
    localparam int TAGW = calc_tagw(OFFW, IDXW);
    localparam int LW   = 32 * LINE_WORDS;

    logic [OFFW-1:0] offset_s;
    logic [IDXW-1:0] index_s;
    logic [TAGW-1:0] tag_s;
    logic [TAGW-1:0] arr_tag_s;
    logic            arr_valid_s;
    logic            arr_dirty_s;
    logic [LW-1:0]   arr_line_s;
    logic [31:0]     word_s;
    logic            access_s;
    logic            hit_s;
    logic            load_hit_s;
    logic            store_hit_s;

    logic            wr_en_s;
    logic            wr_fill_s;
    logic [IDXW-1:0] wr_idx_s;
    logic [OFFW-1:0] wr_off_s;
    logic [TAGW-1:0] wr_tag_s;
    logic [31:0]     wr_word_s;
    logic [LW-1:0]   wr_line_s;

    state_e          state_r;
    logic [TAGW-1:0] miss_tag_r;
    logic [IDXW-1:0] miss_idx_r;
    logic [31:0]     read_data_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [31:0]     mem_addr_r;
    logic [LW-1:0]   mem_wdata_r;

    assign offset_s = OFFW'(addr_offset(ALUOut, OFFW));
    assign index_s  = IDXW'(addr_index(ALUOut, OFFW, IDXW));
    assign tag_s    = TAGW'(addr_tag(ALUOut, TAGW));

    dcache_array #(.NLINES(NLINES), .LINE_WORDS(LINE_WORDS)) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (index_s),
        .rd_tag   (arr_tag_s),
        .rd_valid (arr_valid_s),
        .rd_dirty (arr_dirty_s),
        .rd_line  (arr_line_s),
        .wr_en    (wr_en_s),
        .wr_fill  (wr_fill_s),
        .wr_idx   (wr_idx_s),
        .wr_off   (wr_off_s),
        .wr_tag   (wr_tag_s),
        .wr_word  (wr_word_s),
        .wr_line  (wr_line_s)
    );

    assign word_s      = arr_line_s[{offset_s, 5'd0} +: 32];
    assign access_s    = LoadM | MemWrite;
    assign hit_s       = arr_valid_s && (arr_tag_s == tag_s);
    assign load_hit_s  = LoadM && !MemWrite && (state_r == IDLE) && hit_s;
    assign store_hit_s = MemWrite && (state_r == IDLE) && hit_s;
    assign dhit        = !access_s || ((state_r == IDLE) && hit_s);
    assign ReadData    = load_hit_s ? word_s : read_data_r;

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

    // Array write steering: a completing refill takes precedence over a store hit.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_fill_s = 1'b0;
        wr_idx_s  = index_s;
        wr_off_s  = offset_s;
        wr_tag_s  = miss_tag_r;
        wr_word_s = WriteData;
        wr_line_s = mem.mem_rdata;
        if (!reset && (state_r == REFILL) && mem.mem_ready) begin
            wr_en_s   = 1'b1;
            wr_fill_s = 1'b1;
            wr_idx_s  = miss_idx_r;
        end else if (!reset && store_hit_s) begin
            wr_en_s   = 1'b1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Last delivered load word, held through misses and idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_r <= 32'd0;
        end else if (load_hit_s) begin
            read_data_r <= word_s;
        end
    end

    // Miss FSM with registered memory-side outputs held until mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= '0;
            miss_tag_r  <= '0;
            miss_idx_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s && !hit_s) begin
                        miss_tag_r <= tag_s;
                        miss_idx_r <= index_s;
                        mem_req_r  <= 1'b1;
                        if (arr_valid_s && arr_dirty_s) begin
                            state_r     <= WRITEBACK;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {arr_tag_s, index_s, {(OFFW+2){1'b0}}};
                            mem_wdata_r <= arr_line_s;
                        end else begin
                            state_r    <= REFILL;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {tag_s, index_s, {(OFFW+2){1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem.mem_ready) begin
                        state_r    <= REFILL;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {miss_tag_r, miss_idx_r, {(OFFW+2){1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem.mem_ready) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed self-checking bench for dcache_dm with a hand-driven memory responder.
module tb_dcache_dm;

    logic        clk;
    logic        reset;
    logic        LoadM;
    logic        MemWrite;
    logic [31:0] ALUOut;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        dhit;
    int          n_cmp;
    int          n_mis;

    dcache_if #(.LW(128)) mem_bus ();

    dcache_dm #(.NLINES(8), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .LoadM     (LoadM),
        .MemWrite  (MemWrite),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .dhit      (dhit),
        .mem       (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Land just after a falling edge: outputs of the previous rising edge are settled.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_respond(input logic [127:0] line);
        int n;
        n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("req_seen", {127'd0, mem_bus.mem_req}, 128'd1);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = line;
        tick();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 128'd0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        LoadM = 1'b0;
        MemWrite = 1'b0;
        ALUOut = 32'd0;
        WriteData = 32'd0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 128'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_eq("rst_dhit", {127'd0, dhit}, 128'd1);
        check_eq("rst_rdata", {96'd0, ReadData}, 128'd0);
        check_eq("rst_req", {127'd0, mem_bus.mem_req}, 128'd0);
        check_eq("rst_we", {127'd0, mem_bus.mem_we}, 128'd0);
        check_eq("rst_addr", {96'd0, mem_bus.mem_addr}, 128'd0);
        check_eq("rst_wdata", mem_bus.mem_wdata, 128'd0);

        // Cold miss on 0x100 then refill with words 1..4.
        LoadM = 1'b1;
        ALUOut = 32'h100;
        #1;
        check_eq("cold_dhit0", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("cold_req", {127'd0, mem_bus.mem_req}, 128'd1);
        check_eq("cold_we", {127'd0, mem_bus.mem_we}, 128'd0);
        check_eq("cold_addr", {96'd0, mem_bus.mem_addr}, 128'h100);
        check_eq("cold_dhit1", {127'd0, dhit}, 128'd0);
        mem_respond({32'd4, 32'd3, 32'd2, 32'd1});
        check_eq("cold_hit", {127'd0, dhit}, 128'd1);
        check_eq("cold_rdata", {96'd0, ReadData}, 128'd1);
        check_eq("cold_req_drop", {127'd0, mem_bus.mem_req}, 128'd0);
        ALUOut = 32'h108;
        #1;
        check_eq("hit_108_dhit", {127'd0, dhit}, 128'd1);
        check_eq("hit_108_rdata", {96'd0, ReadData}, 128'd3);

        // Store hit then load back.
        tick();
        LoadM = 1'b0;
        MemWrite = 1'b1;
        ALUOut = 32'h104;
        WriteData = 32'hDEADBEEF;
        #1;
        check_eq("st_dhit", {127'd0, dhit}, 128'd1);
        tick();
        check_eq("st_noreq", {127'd0, mem_bus.mem_req}, 128'd0);
        MemWrite = 1'b0;
        LoadM = 1'b1;
        #1;
        check_eq("st_rb_dhit", {127'd0, dhit}, 128'd1);
        check_eq("st_rb_rdata", {96'd0, ReadData}, 128'hDEADBEEF);

        // Dirty conflict: 0x180 evicts dirty 0x100.
        tick();
        ALUOut = 32'h180;
        #1;
        check_eq("dc_dhit0", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("dc_wb_req", {127'd0, mem_bus.mem_req}, 128'd1);
        check_eq("dc_wb_we", {127'd0, mem_bus.mem_we}, 128'd1);
        check_eq("dc_wb_addr", {96'd0, mem_bus.mem_addr}, 128'h100);
        check_eq("dc_wb_data", mem_bus.mem_wdata, {32'd4, 32'd3, 32'hDEADBEEF, 32'd1});
        mem_respond(128'd0);
        check_eq("dc_rf_req", {127'd0, mem_bus.mem_req}, 128'd1);
        check_eq("dc_rf_we", {127'd0, mem_bus.mem_we}, 128'd0);
        check_eq("dc_rf_addr", {96'd0, mem_bus.mem_addr}, 128'h180);
        check_eq("dc_rf_dhit", {127'd0, dhit}, 128'd0);
        mem_respond({32'd8, 32'd7, 32'd6, 32'd5});
        check_eq("dc_hit", {127'd0, dhit}, 128'd1);
        check_eq("dc_rdata", {96'd0, ReadData}, 128'd5);
        check_eq("dc_req_drop", {127'd0, mem_bus.mem_req}, 128'd0);

        // Clean conflicts: 0x200 then 0x28C, refill only.
        tick();
        ALUOut = 32'h200;
        #1;
        check_eq("cc1_dhit0", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("cc1_we", {127'd0, mem_bus.mem_we}, 128'd0);
        check_eq("cc1_addr", {96'd0, mem_bus.mem_addr}, 128'h200);
        mem_respond({32'hC, 32'hB, 32'hA, 32'h9});
        check_eq("cc1_hit", {127'd0, dhit}, 128'd1);
        check_eq("cc1_rdata", {96'd0, ReadData}, 128'h9);
        check_eq("cc1_req_drop", {127'd0, mem_bus.mem_req}, 128'd0);
        tick();
        ALUOut = 32'h28C;
        #1;
        check_eq("cc2_dhit0", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("cc2_we", {127'd0, mem_bus.mem_we}, 128'd0);
        check_eq("cc2_addr", {96'd0, mem_bus.mem_addr}, 128'h280);
        mem_respond({32'h10, 32'hF, 32'hE, 32'hD});
        check_eq("cc2_hit", {127'd0, dhit}, 128'd1);
        check_eq("cc2_rdata", {96'd0, ReadData}, 128'h10);
        check_eq("cc2_req_drop", {127'd0, mem_bus.mem_req}, 128'd0);

        // Reset in the middle of a refill.
        tick();
        ALUOut = 32'h100;
        #1;
        check_eq("rr_dhit0", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("rr_req", {127'd0, mem_bus.mem_req}, 128'd1);
        reset = 1'b1;
        tick();
        check_eq("rr_req_drop", {127'd0, mem_bus.mem_req}, 128'd0);
        check_eq("rr_addr_clr", {96'd0, mem_bus.mem_addr}, 128'd0);
        reset = 1'b0;
        ALUOut = 32'h280;
        #1;
        check_eq("rr_no_stale_280", {127'd0, dhit}, 128'd0);
        ALUOut = 32'h100;
        #1;
        check_eq("rr_no_stale_100", {127'd0, dhit}, 128'd0);
        tick();
        check_eq("rr_rf_addr", {96'd0, mem_bus.mem_addr}, 128'h100);
        mem_respond({32'h14, 32'h13, 32'h12, 32'h11});
        check_eq("rr_hit", {127'd0, dhit}, 128'd1);
        check_eq("rr_rdata", {96'd0, ReadData}, 128'h11);

        // Spurious mem_ready while idle.
        tick();
        LoadM = 1'b0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = {128{1'b1}};
        #1;
        check_eq("sp_dhit", {127'd0, dhit}, 128'd1);
        tick();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 128'd0;
        #1;
        check_eq("sp_req", {127'd0, mem_bus.mem_req}, 128'd0);
        check_eq("sp_dhit_after", {127'd0, dhit}, 128'd1);
        check_eq("sp_rdata_hold", {96'd0, ReadData}, 128'h11);
        LoadM = 1'b1;
        ALUOut = 32'h104;
        #1;
        check_eq("sp_hit_104", {127'd0, dhit}, 128'd1);
        check_eq("sp_rdata_104", {96'd0, ReadData}, 128'h12);

        tick();
        LoadM = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
